// File: rtl/data_ddr_bridge_pkg.sv
// rtl/data_ddr_bridge_pkg.sv - shared state codes, request sources and length width for the data DDR bridge
package data_ddr_bridge_pkg;

  localparam int BURST_LEN_W = 10;

  localparam logic [3:0] IDLE                 = 4'd0;
  localparam logic [3:0] MEM_READ_DATA        = 4'd1;
  localparam logic [3:0] MEM_READ_JMP         = 4'd2;
  localparam logic [3:0] MEM_WRITE_DATA_STORE = 4'd9;
  localparam logic [3:0] MEM_DONE             = 4'd10;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_READ  = 2'd1;
  localparam logic [1:0] SRC_JMP   = 2'd2;
  localparam logic [1:0] SRC_STORE = 2'd3;

  // The count sticks at all-ones so the cache's "count > depth" exit stays true.
  function automatic logic [BURST_LEN_W-1:0] sat_inc(input logic [BURST_LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/data_ddr_bridge_ddr_req_arbiter.sv
// rtl/data_ddr_bridge_ddr_req_arbiter.sv - fixed-priority request grant with address/length latch
module ddr_req_arbiter
  import data_ddr_bridge_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BURST_LEN      = 16,
  parameter int JMP_BURST_LEN  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      grant_en,
  input  logic                      store_req,
  input  logic                      read_req,
  input  logic                      jmp_req,
  input  logic [DDR_ADDR_WIDTH-1:0] read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] write_addr,
  output logic [1:0]                grant,
  output logic [1:0]                owner,
  output logic [DDR_ADDR_WIDTH-1:0] rd_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_addr,
  output logic [BURST_LEN_W-1:0]    rd_len,
  output logic [BURST_LEN_W-1:0]    wr_len
);

  always_comb begin
    grant = SRC_NONE;
    if (store_req)     grant = SRC_STORE;
    else if (read_req) grant = SRC_READ;
    else if (jmp_req)  grant = SRC_JMP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner   <= SRC_NONE;
      rd_addr <= '0;
      wr_addr <= '0;
      rd_len  <= '0;
      wr_len  <= '0;
    end else if (grant_en && grant != SRC_NONE) begin
      owner <= grant;
      case (grant)
        SRC_STORE: begin
          wr_addr <= write_addr;
          wr_len  <= BURST_LEN_W'(BURST_LEN);
        end
        SRC_READ: begin
          rd_addr <= read_addr;
          rd_len  <= BURST_LEN_W'(BURST_LEN);
        end
        default: begin
          rd_addr <= read_addr;
          rd_len  <= BURST_LEN_W'(JMP_BURST_LEN);
        end
      endcase
    end
  end

endmodule

// File: rtl/data_ddr_bridge.sv
// rtl/data_ddr_bridge.sv - data cache to DDR burst controller bridge; watchdog under DATA_DDR_BRIDGE_TIMEOUT_EN
module data_ddr_bridge
  import data_ddr_bridge_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_LEN      = 16,
  parameter int JMP_BURST_LEN  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req,
  input  logic                      DATA_store_req,
  input  logic                      JMP_ADDR_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  input  logic                      data_to_ddr_rdy,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic [BURST_LEN_W-1:0]    rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      rd_burst_req,
  output logic                      wr_burst_req,
  output logic [BURST_LEN_W-1:0]    rd_burst_len,
  output logic [BURST_LEN_W-1:0]    wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic [DATA_WIDTH-1:0]     rd_burst_data,
  input  logic                      rd_burst_data_valid_in,
  input  logic                      wr_burst_data_req_in,
  output logic [DATA_WIDTH-1:0]     wr_burst_data,
  input  logic                      rd_burst_finish,
  input  logic                      wr_burst_finish
`ifdef DATA_DDR_BRIDGE_TIMEOUT_EN
  ,
  output logic                      bridge_err
`endif
);

  logic [3:0] state, next_state;
  logic [1:0] grant, owner;
  logic       owner_req;
  logic       req_pending;
  logic       in_read, in_write, beat, timeout;

  ddr_req_arbiter #(
    .DDR_ADDR_WIDTH(DDR_ADDR_WIDTH),
    .BURST_LEN     (BURST_LEN),
    .JMP_BURST_LEN (JMP_BURST_LEN)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .grant_en  (state == IDLE),
    .store_req (DATA_store_req),
    .read_req  (DATA_read_req),
    .jmp_req   (JMP_ADDR_read_req),
    .read_addr (DATA_read_addr),
    .write_addr(DATA_write_addr),
    .grant     (grant),
    .owner     (owner),
    .rd_addr   (rd_burst_addr),
    .wr_addr   (wr_burst_addr),
    .rd_len    (rd_burst_len),
    .wr_len    (wr_burst_len)
  );

  assign in_read  = (state == MEM_READ_DATA) || (state == MEM_READ_JMP);
  assign in_write = (state == MEM_WRITE_DATA_STORE);
  assign beat     = (in_read && rd_burst_data_valid_in) || (in_write && wr_burst_data_req_in);

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      SRC_STORE: owner_req = DATA_store_req;
      SRC_READ:  owner_req = DATA_read_req;
      SRC_JMP:   owner_req = JMP_ADDR_read_req;
      default:   owner_req = 1'b0;
    endcase
  end

`ifdef DATA_DDR_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;

  assign timeout = (in_read || in_write) && !beat && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt     <= '0;
      bridge_err <= 1'b0;
    end else begin
      to_cnt <= ((in_read || in_write) && !beat) ? to_cnt + 1'b1 : '0;
      if (timeout) bridge_err <= 1'b1;
    end
  end
`else
  // Watchdog absent: never fires.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (grant)
          SRC_STORE: next_state = MEM_WRITE_DATA_STORE;
          SRC_READ:  next_state = MEM_READ_DATA;
          SRC_JMP:   next_state = MEM_READ_JMP;
          default:   next_state = IDLE;
        endcase
      end
      MEM_READ_DATA, MEM_READ_JMP: if (rd_burst_finish) next_state = MEM_DONE;
      MEM_WRITE_DATA_STORE:        if (wr_burst_finish) next_state = MEM_DONE;
      MEM_DONE:                    if (!owner_req)      next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
    if (timeout) next_state = MEM_DONE;
  end

  always_comb begin
    state_interface_module = state;
    rd_burst_req           = in_read && req_pending;
    wr_burst_req           = in_write && req_pending;
    wr_burst_data_req      = in_write && wr_burst_data_req_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_pending         <= 1'b0;
      DATA_to_cache       <= '0;
      JMP_ADDR_to_cache   <= '0;
      rd_cnt_data         <= '0;
      rd_burst_data_valid <= 1'b0;
      wr_burst_data       <= '0;
    end else begin
      rd_burst_data_valid <= 1'b0;
      // Request stays up until the controller's first beat acknowledges it.
      if (state == IDLE) req_pending <= 1'b1;
      else if (beat)     req_pending <= 1'b0;

      if (state == IDLE && (next_state == MEM_READ_DATA || next_state == MEM_READ_JMP)) begin
        rd_cnt_data <= '0;
      end else if (timeout) begin
        rd_cnt_data <= '1;
      end else if (in_read && rd_burst_data_valid_in) begin
        DATA_to_cache       <= rd_burst_data;
        rd_burst_data_valid <= 1'b1;
        rd_cnt_data         <= sat_inc(rd_cnt_data);
        if (state == MEM_READ_JMP && rd_cnt_data == '0)
          JMP_ADDR_to_cache <= DDR_ADDR_WIDTH'(rd_burst_data);
      end

      if (data_to_ddr_rdy) wr_burst_data <= DATA_to_ddr;
    end
  end

endmodule
